// File: rtl/serial_alu_seq_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_PASSB = 3'b000,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } seq_state_t;

    function automatic logic is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// Request/result bundle between operand fetch and the serial ALU.
interface serial_alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start, A, B, cntrl,
        input  result, busy, done, negative, zero, overflow, carry_out
    );

    modport slave (
        input  start, A, B, cntrl,
        output result, busy, done, negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/serial_alu_seq_bit_slice.sv
// One-bit ALU slice; subtract is add with b inverted and the carry preset by the caller.
module serial_bit_slice
    import alu_pkg::*;
(
    input  logic    i_a,
    input  logic    i_b,
    input  logic    i_cin,
    input  alu_op_t i_op,
    output logic    o_sum,
    output logic    o_cout
);

    logic w_b;

    always_comb begin
        w_b    = (i_op == OP_SUB) ? ~i_b : i_b;
        o_sum  = 1'b0;
        o_cout = i_cin;
        case (i_op)
            OP_PASSB: o_sum = i_b;
            OP_ADD, OP_SUB: begin
                o_sum  = i_a ^ w_b ^ i_cin;
                o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);
            end
            OP_AND:   o_sum = i_a & i_b;
            OP_OR:    o_sum = i_a | i_b;
            OP_XOR:   o_sum = i_a ^ i_b;
            default:  o_sum = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: streams operands LSB-first through one slice, one bit per clock.
// state   | meaning
// IDLE    | waiting for start
// RUN     | processing bit r_count
// DONE    | result/flags valid, done high; start here chains the next op
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    serial_alu_seq_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    seq_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    alu_op_t          r_op;
    logic [CNT_W-1:0] r_count;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;

    logic             w_sum;
    logic             w_cout;
    logic             w_arith;
    logic             w_last;
    logic [WIDTH-1:0] w_next_acc;

    serial_bit_slice u_slice (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .i_op   (r_op),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_arith    = is_arith(r_op);
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));
    assign w_next_acc = {w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_op     <= OP_PASSB;
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_acc <= w_next_acc;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    if (w_arith) r_carry <= w_cout;
                    if (w_last) begin
                        // r_carry still holds the carry into the MSB here
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_next_acc;
                        r_n      <= w_sum;
                        r_z      <= (w_next_acc == '0);
                        r_c      <= w_arith & w_cout;
                        r_v      <= w_arith & (r_carry ^ w_cout);
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_op    <= alu_op_t'(bus.cntrl);
                        r_count <= '0;
                        r_carry <= (bus.cntrl == OP_SUB);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.result    = r_result;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.negative  = r_n;
    assign bus.zero      = r_z;
    assign bus.carry_out = r_c;
    assign bus.overflow  = r_v;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq: a 64-bit instance and an 8-bit instance on one clock.
module tb_serial_alu_seq;

    logic clk = 1'b0;
    logic rst64;
    logic rst8;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_alu_seq_if #(.WIDTH(64)) if64 ();
    serial_alu_seq_if #(.WIDTH(8))  if8 ();

    serial_alu_seq #(.WIDTH(64)) u_dut64 (.clk(clk), .reset(rst64), .bus(if64.slave));
    serial_alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(rst8),  .bus(if8.slave));

    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        output int cyc, output logic to);
        @(negedge clk);
        if64.start = 1'b1; if64.A = a; if64.B = b; if64.cntrl = op;
        @(negedge clk);
        if64.start = 1'b0;
        cyc = 0;
        while (!if64.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        to = (cyc >= 200);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       output int cyc, output logic to);
        @(negedge clk);
        if8.start = 1'b1; if8.A = a; if8.B = b; if8.cntrl = op;
        @(negedge clk);
        if8.start = 1'b0;
        cyc = 0;
        while (!if8.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        to = (cyc >= 100);
    endtask

    task automatic test_reset();
        rst64 = 1'b1; rst8 = 1'b1;
        if64.start = 1'b0; if64.A = '0; if64.B = '0; if64.cntrl = 3'b000;
        if8.start = 1'b0;  if8.A = '0;  if8.B = '0;  if8.cntrl = 3'b000;
        repeat (2) @(negedge clk);
        checks++; if (if64.result !== 64'h0) begin errors++; $display("FAIL reset_result64 got %h exp 0", if64.result); end
        checks++; if ({if64.busy, if64.done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done64 got %b exp 00", {if64.busy, if64.done}); end
        checks++; if ({if64.negative, if64.zero, if64.carry_out, if64.overflow} !== 4'b0000) begin errors++; $display("FAIL reset_flags64 got %b exp 0000", {if64.negative, if64.zero, if64.carry_out, if64.overflow}); end
        checks++; if ({if8.result, if8.busy, if8.done, if8.negative, if8.zero, if8.carry_out, if8.overflow} !== 14'h0) begin errors++; $display("FAIL reset_all8 got %h exp 0", {if8.result, if8.busy, if8.done, if8.negative, if8.zero, if8.carry_out, if8.overflow}); end
        rst64 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        checks++; if ({if64.busy, if64.done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b exp 00", {if64.busy, if64.done}); end
    endtask

    task automatic test_add();
        int cyc; logic to;
        op64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'b010, cyc, to);
        checks++; if (to || cyc != 64) begin errors++; $display("FAIL add_latency got %0d exp 64 (timeout=%0b)", cyc, to); end
        checks++; if (if64.result !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_result got %h exp 8000000000000000", if64.result); end
        checks++; if ({if64.negative, if64.zero, if64.carry_out, if64.overflow} !== 4'b1001) begin errors++; $display("FAIL add_nzcv got %b exp 1001", {if64.negative, if64.zero, if64.carry_out, if64.overflow}); end
        @(negedge clk);
        checks++; if (if64.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse_width got %b exp 0", if64.done); end
    endtask

    task automatic test_sub();
        int cyc; logic to;
        op64(64'd5, 64'd5, 3'b011, cyc, to);
        checks++; if (to || if64.result !== 64'h0) begin errors++; $display("FAIL sub_eq_result got %h exp 0 (timeout=%0b)", if64.result, to); end
        checks++; if ({if64.negative, if64.zero, if64.carry_out, if64.overflow} !== 4'b0110) begin errors++; $display("FAIL sub_eq_nzcv got %b exp 0110", {if64.negative, if64.zero, if64.carry_out, if64.overflow}); end
        op64(64'd3, 64'd5, 3'b011, cyc, to);
        checks++; if (to || if64.result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_neg_result got %h exp fffffffffffffffe (timeout=%0b)", if64.result, to); end
        checks++; if ({if64.negative, if64.zero, if64.carry_out, if64.overflow} !== 4'b1000) begin errors++; $display("FAIL sub_neg_nzcv got %b exp 1000", {if64.negative, if64.zero, if64.carry_out, if64.overflow}); end
    endtask

    task automatic test_logic();
        int cyc; logic to;
        logic [63:0] a_v = 64'hF0F0_F0F0_F0F0_F0F0;
        logic [63:0] b_v = 64'hFF00_FF00_FF00_FF00;
        logic [2:0]  ops [4]  = '{3'b100, 3'b101, 3'b110, 3'b000};
        logic [63:0] exp_r [4] = '{64'hF000_F000_F000_F000, 64'hFFF0_FFF0_FFF0_FFF0,
                                   64'h0FF0_0FF0_0FF0_0FF0, 64'hFF00_FF00_FF00_FF00};
        logic [3:0]  exp_f [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            op64(a_v, b_v, ops[i], cyc, to);
            checks++; if (to || if64.result !== exp_r[i]) begin errors++; $display("FAIL logic_result op=%b got %h exp %h (timeout=%0b)", ops[i], if64.result, exp_r[i], to); end
            checks++; if ({if64.negative, if64.zero, if64.carry_out, if64.overflow} !== exp_f[i]) begin errors++; $display("FAIL logic_nzcv op=%b got %b exp %b", ops[i], {if64.negative, if64.zero, if64.carry_out, if64.overflow}, exp_f[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int n = 0;
        @(negedge clk);
        if64.start = 1'b1; if64.A = 64'd1; if64.B = 64'd2; if64.cntrl = 3'b010;
        @(negedge clk);
        if64.start = 1'b0;
        repeat (10) begin @(negedge clk); n++; end
        if64.start = 1'b1; if64.A = 64'd100; if64.B = 64'd200;
        @(negedge clk); n++;
        if64.start = 1'b0;
        checks++; if (if64.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b exp 1", if64.busy); end
        while (!if64.done && n < 200) begin @(negedge clk); n++; end
        checks++; if (n != 64) begin errors++; $display("FAIL ignore_latency got %0d exp 64", n); end
        checks++; if (if64.result !== 64'd3) begin errors++; $display("FAIL ignore_result got %h exp 3", if64.result); end
        @(negedge clk);
        checks++; if ({if64.busy, if64.done} !== 2'b00) begin errors++; $display("FAIL ignore_no_queue got %b exp 00", {if64.busy, if64.done}); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int g = 0;
        @(negedge clk);
        if64.start = 1'b1; if64.A = 64'd10; if64.B = 64'd20; if64.cntrl = 3'b010;
        while (!if64.done && n < 200) begin @(negedge clk); n++; end
        checks++; if (n != 65 || if64.result !== 64'd30) begin errors++; $display("FAIL b2b_first got n=%0d res=%h exp n=65 res=1e", n, if64.result); end
        if64.A = 64'd100; if64.B = 64'd1; if64.cntrl = 3'b011;
        @(negedge clk); g++;
        if64.start = 1'b0;
        checks++; if ({if64.busy, if64.done} !== 2'b10) begin errors++; $display("FAIL b2b_no_gap got %b exp 10", {if64.busy, if64.done}); end
        repeat (20) begin @(negedge clk); g++; end
        checks++; if (if64.result !== 64'd30) begin errors++; $display("FAIL b2b_result_held got %h exp 1e", if64.result); end
        while (!if64.done && g < 200) begin @(negedge clk); g++; end
        checks++; if (g != 65) begin errors++; $display("FAIL b2b_done_spacing got %0d exp 65", g); end
        checks++; if (if64.result !== 64'd99 || {if64.negative, if64.zero, if64.carry_out, if64.overflow} !== 4'b0010) begin errors++; $display("FAIL b2b_second got %h/%b exp 63/0010", if64.result, {if64.negative, if64.zero, if64.carry_out, if64.overflow}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int cyc; logic to;
        int seen = 0;
        op8(8'h7F, 8'h01, 3'b010, cyc, to);
        checks++; if (to || cyc != 8) begin errors++; $display("FAIL w8_latency got %0d exp 8 (timeout=%0b)", cyc, to); end
        checks++; if (if8.result !== 8'h80 || {if8.negative, if8.zero, if8.carry_out, if8.overflow} !== 4'b1001) begin errors++; $display("FAIL w8_add got %h/%b exp 80/1001", if8.result, {if8.negative, if8.zero, if8.carry_out, if8.overflow}); end
        @(negedge clk);
        if8.start = 1'b1; if8.A = 8'h0F; if8.B = 8'h01; if8.cntrl = 3'b010;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b exp 1", if8.busy); end
        rst8 = 1'b1;
        #1;
        checks++; if (if8.result !== 8'h00 || {if8.busy, if8.done} !== 2'b00) begin errors++; $display("FAIL rst_mid_async got res=%h bd=%b exp 00/00", if8.result, {if8.busy, if8.done}); end
        checks++; if ({if8.negative, if8.zero, if8.carry_out, if8.overflow} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got %b exp 0000", {if8.negative, if8.zero, if8.carry_out, if8.overflow}); end
        @(negedge clk);
        rst8 = 1'b0;
        repeat (12) begin @(negedge clk); if (if8.done) seen++; end
        checks++; if (seen != 0 || if8.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done got done_count=%0d busy=%b exp 0/0", seen, if8.busy); end
        op8(8'h05, 8'h03, 3'b011, cyc, to);
        checks++; if (to || cyc != 8 || if8.result !== 8'h02) begin errors++; $display("FAIL rst_recover_result got %h cyc=%0d exp 02 cyc=8", if8.result, cyc); end
        checks++; if ({if8.negative, if8.zero, if8.carry_out, if8.overflow} !== 4'b0010) begin errors++; $display("FAIL rst_recover_nzcv got %b exp 0010", {if8.negative, if8.zero, if8.carry_out, if8.overflow}); end
    endtask

    task automatic test_unused_codes();
        int cyc; logic to;
        op8(8'hFF, 8'hFF, 3'b111, cyc, to);
        checks++; if (to || if8.result !== 8'h00) begin errors++; $display("FAIL code111_result got %h exp 00 (timeout=%0b)", if8.result, to); end
        checks++; if ({if8.negative, if8.zero, if8.carry_out, if8.overflow} !== 4'b0100) begin errors++; $display("FAIL code111_nzcv got %b exp 0100", {if8.negative, if8.zero, if8.carry_out, if8.overflow}); end
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b001, cyc, to);
        checks++; if (to || if64.result !== 64'h0) begin errors++; $display("FAIL code001_result got %h exp 0 (timeout=%0b)", if64.result, to); end
        checks++; if ({if64.negative, if64.zero, if64.carry_out, if64.overflow} !== 4'b0100) begin errors++; $display("FAIL code001_nzcv got %b exp 0100", {if64.negative, if64.zero, if64.carry_out, if64.overflow}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_unused_codes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got running exp finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial ALU sequencer for the 64-bit datapath. Latches two operands and an ALU control code on a `start` handshake and streams them LSB-first through a one-bit datapath slice, one bit per clock, carrying between bits in a flop. When the word is complete it presents the result and the NZCV flags with a one-cycle `done` pulse. It sits between operand fetch and the flag/writeback logic as an area-reduced alternative to the parallel ALU.

## Interface
- `WIDTH`, 64, operand and result width in bits (≥ 2).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request. Sampled only when `busy` = 0.
- `A`  in  WIDTH  operand A. Captured on an accepted `start`.
- `B`  in  WIDTH  operand B. Captured on an accepted `start`.
- `cntrl`  in  3  operation code:
  - 000 pass B
  - 010 add
  - 011 subtract (A−B)
  - 100 and
  - 101 or
  - 110 xor
- `result`  out  WIDTH  final result. Held until the next accepted `start`.
- `busy`  out  1  high while the operation is in progress.
- `done`  out  1  one-cycle pulse when `result` and the flags are valid.
- `negative`, `zero`, `overflow`, `carry_out`  out  1 each  NZCV flags. Held with `result`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --bit count = WIDTH−1--> DONE.
  - DONE --start--> RUN.
  - DONE --no start--> IDLE.
- On an accepted start:
  - Load A and B into shift registers and latch `cntrl`.
  - Bit counter ← 0.
  - Carry flop ← 1 for subtract, otherwise 0.
- Each RUN cycle processes bit i = count, LSB first.
  - Add: sum = a^b^c, carry ← majority(a, b, c).
  - Subtract: the same, with b inverted.
  - Logic ops: bitwise; the carry flop is unchanged.
  - The result bit shifts in at the MSB of the result register (shift right). Operand registers shift right.
- Overflow: the carry into the MSB is recorded during the last bit. V = carry_in(MSB) ^ carry_out(MSB) for add/sub, else 0.
- C = final carry for add/sub, else 0. Subtract C follows ARM convention: 1 = no borrow.
- N = result[WIDTH−1]. Z = (result == 0).
- Unused codes 001 and 111 produce an all-zero result, with Z = 1 and N = C = V = 0.
- `start` while in RUN is ignored. No queueing, no error.
- Reset in any state:
  - Abort immediately to IDLE; no `done` is issued.
  - `result`, all flags, `busy`, `done`, counter and carry all go to 0.

## Timing
- Accepted start at edge k:
  - `busy` = 1 from after edge k until edge k+WIDTH.
  - The FSM enters DONE at edge k+WIDTH.
  - `done` = 1 for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
- Latency: WIDTH+1 cycles from start sample to the end of the `done` pulse.
- `result` and flags change only at the edge entering DONE. They are stable from then until the next accepted start completes. Mid-operation values stay in an internal register and are never visible on `result`.
- Back-to-back: a start sampled during DONE is accepted. Throughput is one operation per WIDTH+1 cycles with no idle gap.
- `busy` = (state == RUN), registered. `done` = (state == DONE), registered.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum for the 3-bit `cntrl` codes.
  - `seq_state_t` enum for IDLE, RUN, DONE.
  - Constant `ALU_WIDTH` = 64.
- One sub-module, `serial_bit_slice`. It is combinational and takes a, b, cin and op, and returns sum, cout.
- Carry flop, counter (width $clog2(WIDTH)), shift registers and FSM live in `serial_alu_seq`.

## Test plan
Scenarios 1–4 use WIDTH = 64; scenarios 5 and 6 use WIDTH = 8.
1. Add: A=0x7FFF_FFFF_FFFF_FFFF, B=1, cntrl=010.
   - `done` exactly 64 cycles after start.
   - result=0x8000_0000_0000_0000, N=1, Z=0, C=0, V=1.
2. Subtract: A=5, B=5, cntrl=011.
   - result=0, Z=1, C=1, V=0, N=0.
   - Then A=3, B=5 → result=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0.
3. Logic: A=0xF0F0…F0, B=0xFF00…FF00.
   - cntrl=100 → 0xF000…F000.
   - cntrl=101 → 0xFFF0…FFF0.
   - cntrl=110 → 0x0FF0…0FF0.
   - cntrl=000 → B.
   - C=V=0 in every case.
4. Handshake:
   - Pulse start again 10 cycles into RUN: ignored, `result` matches the first op.
   - Hold start high through DONE: the second op starts with no gap, and two `done` pulses are 65 cycles apart.
5. Reset mid-RUN (cycle 4 of 8): all outputs go to 0 asynchronously, no `done`. A new op afterwards completes correctly.
6. Code 111 with A=0xFF, B=0xFF: result=0, Z=1, N=C=V=0.
